// File: rtl/tag_ram_pkg.sv
// tag_ram_pkg: shared types and helpers for the multi-way tag store.
package tag_ram_pkg;
  typedef enum logic [1:0] {
    ST_RESET,
    ST_CLEAR,
    ST_IDLE
  } state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/tag_way_ram.sv
// tag_way_ram: one way of tag storage; synchronous write, latched read address so a
// same-edge write is visible to the read (write-first).
module tag_way_ram #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 15
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data
);
  localparam int DEPTH = 1 << AWIDTH;
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH-1:0] addr_q;
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) addr_q <= rd_addr;
  end
  assign rd_data = mem[addr_q];
endmodule

// File: rtl/tag_ram_nway.sv
// tag_ram_nway: N-way tag store with registered hit/miss lookup, per-set round-robin
// victim pointer and a hardware invalidate sweep after reset or on request.
module tag_ram_nway
  import tag_ram_pkg::*;
#(
  parameter int AWIDTH = 3,
  parameter int TWIDTH = 14,
  parameter int WAYS = 2,
  localparam int DEPTH = 1 << AWIDTH,
  localparam int WWIDTH = clog2(WAYS) < 1 ? 1 : clog2(WAYS)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              lookup_valid,
  input  logic [AWIDTH-1:0] lookup_index,
  input  logic [TWIDTH-1:0] lookup_tag,
  output logic              resp_valid,
  output logic              hit,
  output logic [WWIDTH-1:0] hit_way,
  output logic [WWIDTH-1:0] victim_way,
  input  logic              fill_en,
  input  logic [AWIDTH-1:0] fill_index,
  input  logic [WWIDTH-1:0] fill_way,
  input  logic [TWIDTH-1:0] fill_tag,
  input  logic              inv_all,
  output logic              busy
);
  state_t state, state_nx;
  logic [AWIDTH-1:0] cnt, cnt_nx, idx_q;
  logic [TWIDTH-1:0] tag_q;
  logic clr, look, fill, lk_q;
  logic [WAYS-1:0] vld, match;
  logic [TWIDTH:0] rd [WAYS];
  logic [WWIDTH-1:0] hit_way_nx, inv_way, victim_nx, rr_cur;
  always_comb begin
    state_nx = state == ST_RESET ? ST_CLEAR :
               state == ST_CLEAR ? (cnt == '1 ? ST_IDLE : ST_CLEAR) :
               inv_all ? ST_CLEAR : ST_IDLE;
    cnt_nx = state == ST_CLEAR ? cnt + 1'b1 : '0;
    busy = state != ST_IDLE;
    clr = state == ST_CLEAR;
    look = !busy && reset_n && lookup_valid;
    fill = !busy && reset_n && fill_en;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= ST_RESET;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  end
  always_ff @(posedge clock) begin
    lk_q <= look;
    if (look) begin
      idx_q <= lookup_index;
      tag_q <= lookup_tag;
    end
  end
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    tag_way_ram #(.AWIDTH(AWIDTH), .DWIDTH(TWIDTH + 1)) u_ram (
      .clock   (clock),
      .wr_en   (clr || (fill && (WAYS == 1 || fill_way == WWIDTH'(w)))),
      .wr_addr (clr ? cnt : fill_index),
      .wr_data (clr ? '0 : {1'b1, fill_tag}),
      .rd_en   (look),
      .rd_addr (lookup_index),
      .rd_data (rd[w])
    );
    assign vld[w] = rd[w][TWIDTH];
    assign match[w] = vld[w] && rd[w][TWIDTH-1:0] == tag_q;
  end
  // Round-robin pointers only exist when there is more than one way to choose from.
  if (WAYS > 1) begin : g_rr
    logic [WWIDTH-1:0] rr [DEPTH];
    always_ff @(posedge clock) begin
      if (clr) rr[cnt] <= '0;
      else if (fill && fill_way == rr[fill_index]) rr[fill_index] <= rr[fill_index] + 1'b1;
    end
    assign rr_cur = rr[idx_q];
  end else begin : g_no_rr
    assign rr_cur = '0;
  end
  always_comb begin
    hit_way_nx = '0;
    inv_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (match[i]) hit_way_nx = WWIDTH'(i);
      if (!vld[i]) inv_way = WWIDTH'(i);
    end
    victim_nx = &vld ? rr_cur : inv_way;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      resp_valid <= 1'b0;
      hit <= 1'b0;
      hit_way <= '0;
      victim_way <= '0;
    end else begin
      resp_valid <= lk_q;
      if (lk_q) begin
        hit <= |match;
        hit_way <= hit_way_nx;
        victim_way <= victim_nx;
      end
    end
  end
  always_ff @(posedge clock)
    if (reset_n && lk_q) assert ($onehot0(match)) else $error("tag_ram_nway: multiple ways hit in set %0d", idx_q);
endmodule

// File: tb/tb_tag_ram_nway.sv
// tb_tag_ram_nway: directed stimulus with a per-cycle reference model of the tag store.
module tb_tag_ram_nway;
  localparam int AW = 3, TW = 14, WAYS = 2, DEPTH = 8;
  logic clock = 0, reset_n = 0, lookup_valid = 0, fill_en = 0, inv_all = 0, fill_way = 0;
  logic [AW-1:0] lookup_index = '0, fill_index = '0;
  logic [TW-1:0] lookup_tag = '0, fill_tag = '0;
  logic resp_valid, hit, hit_way, victim_way, busy;
  int checks = 0, errors = 0;

  tag_ram_nway #(.AWIDTH(AW), .TWIDTH(TW), .WAYS(WAYS)) dut (
    .clock(clock), .reset_n(reset_n),
    .lookup_valid(lookup_valid), .lookup_index(lookup_index), .lookup_tag(lookup_tag),
    .resp_valid(resp_valid), .hit(hit), .hit_way(hit_way), .victim_way(victim_way),
    .fill_en(fill_en), .fill_index(fill_index), .fill_way(fill_way), .fill_tag(fill_tag),
    .inv_all(inv_all), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference model: contents, valid bits and pointers as plain arrays; sweep as a countdown.
  bit mv [DEPTH][WAYS];
  logic [TW-1:0] mt [DEPTH][WAYS];
  int mrr [DEPTH];
  bit m_rst = 1, started = 0, pend = 0;
  int m_left = 0, m_pos = 0;
  int p_hit = 0, p_hw = 0, p_vw = 0;
  int e_rv = 0, e_hit = 0, e_hw = 0, e_vw = 0, e_busy = 1;

  always @(posedge clock) begin
    started = 1;
    e_rv = 0;
    if (!reset_n) begin
      m_rst = 1; m_left = 0; pend = 0;
      e_hit = 0; e_hw = 0; e_vw = 0;
    end else begin
      if (pend) begin
        e_rv = 1; e_hit = p_hit; e_hw = p_hw; e_vw = p_vw;
      end
      pend = 0;
      if (m_rst) begin
        m_rst = 0; m_left = DEPTH; m_pos = 0;
      end else if (m_left > 0) begin
        for (int w = 0; w < WAYS; w++) mv[m_pos][w] = 0;
        mrr[m_pos] = 0;
        m_pos++;
        m_left--;
      end else begin
        if (fill_en) begin
          mv[fill_index][fill_way] = 1;
          mt[fill_index][fill_way] = fill_tag;
          if (int'(fill_way) == mrr[fill_index]) mrr[fill_index] = (mrr[fill_index] + 1) % WAYS;
        end
        if (lookup_valid) begin
          pend = 1; p_hit = 0; p_hw = 0; p_vw = -1;
          for (int w = 0; w < WAYS; w++) begin
            if (p_hit == 0 && mv[lookup_index][w] && mt[lookup_index][w] == lookup_tag) begin
              p_hit = 1; p_hw = w;
            end
            if (p_vw < 0 && !mv[lookup_index][w]) p_vw = w;
          end
          if (p_vw < 0) p_vw = mrr[lookup_index];
        end
        if (inv_all) begin
          m_left = DEPTH; m_pos = 0;
        end
      end
    end
    e_busy = (m_rst || m_left > 0) ? 1 : 0;
  end

  always @(negedge clock) begin
    if (started) begin
      chk("busy", busy, e_busy);
      chk("resp_valid", resp_valid, e_rv);
      chk("hit", hit, e_hit);
      chk("hit_way", hit_way, e_hw);
      chk("victim_way", victim_way, e_vw);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      step();
    end
  endtask

  task automatic fill(input int i, input int w, input int t);
    fill_en = 1; fill_index = AW'(i); fill_way = 1'(w); fill_tag = TW'(t);
    step();
    fill_en = 0;
  endtask

  task automatic look(input string nm, input int i, input int t, input int h, input int hw, input int vw);
    lookup_valid = 1; lookup_index = AW'(i); lookup_tag = TW'(t);
    step();
    lookup_valid = 0;
    step();
    chk({nm, "_rv"}, resp_valid, 1);
    chk({nm, "_hit"}, hit, h);
    chk({nm, "_hw"}, hit_way, hw);
    chk({nm, "_vw"}, victim_way, vw);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) step();
    chk("rst_busy", busy, 1);
    chk("rst_rv", resp_valid, 0);
    chk("rst_hit", hit, 0);
    chk("rst_hw", hit_way, 0);
    chk("rst_vw", victim_way, 0);
    reset_n = 1;
    step();
    busy_len(n);
    chk("release_busy_len", n, 8);
    look("first", 5, 'h1234, 0, 0, 0);
    fill(2, 0, 'h0AA);
    fill(2, 1, 'h0BB);
    look("s2_bb", 2, 'h0BB, 1, 1, 0);
    look("s2_cc", 2, 'h0CC, 0, 0, 0);
    fill(3, 1, 'h101);
    look("s3_w1", 3, 'h101, 1, 1, 0);
    fill(3, 0, 'h111);
    look("s3_rr_a", 3, 'h111, 1, 0, 1);
    fill(3, 0, 'h122);
    look("s3_rr_b", 3, 'h122, 1, 0, 1);
    fill(3, 0, 'h133);
    look("s3_rr_c", 3, 'h133, 1, 0, 1);
    fill(3, 1, 'h144);
    look("s3_wrap", 3, 'h144, 1, 1, 0);
    fill_en = 1; fill_index = 4; fill_way = 0; fill_tag = 'h155;
    lookup_valid = 1; lookup_index = 4; lookup_tag = 'h155;
    step();
    fill_en = 0; lookup_valid = 0;
    step();
    chk("wf_rv", resp_valid, 1);
    chk("wf_hit", hit, 1);
    chk("wf_hw", hit_way, 0);
    chk("wf_vw", victim_way, 1);
    lookup_valid = 1; lookup_index = 2; lookup_tag = 'h0AA;
    step();
    lookup_index = 3; lookup_tag = 'h144;
    step();
    lookup_valid = 0;
    chk("b2b1_hit", hit, 1);
    chk("b2b1_hw", hit_way, 0);
    step();
    chk("b2b2_rv", resp_valid, 1);
    chk("b2b2_hw", hit_way, 1);
    inv_all = 1;
    fill_en = 1; fill_index = 5; fill_way = 1; fill_tag = 'h2AA;
    lookup_valid = 1; lookup_index = 2; lookup_tag = 'h0AA;
    step();
    fill_index = 4; fill_tag = 'h3FF; lookup_tag = 'h0BB;
    step();
    chk("inv_look_rv", resp_valid, 1);
    chk("inv_look_hit", hit, 1);
    step();
    chk("busy_ignore_rv", resp_valid, 0);
    inv_all = 0; fill_en = 0; lookup_valid = 0;
    busy_len(n);
    chk("inv_busy_len", 2 + n, 8);
    look("inv_bb", 2, 'h0BB, 0, 0, 0);
    look("inv_144", 3, 'h144, 0, 0, 0);
    look("inv_155", 4, 'h155, 0, 0, 0);
    look("inv_2aa", 5, 'h2AA, 0, 0, 0);
    look("inv_3ff", 4, 'h3FF, 0, 0, 0);
    lookup_valid = 1; lookup_index = 2; lookup_tag = 'h0;
    step();
    lookup_valid = 0; reset_n = 0;
    step();
    chk("drop_rv", resp_valid, 0);
    reset_n = 1;
    step();
    step();
    step();
    reset_n = 0;
    step();
    chk("midsweep_rst_busy", busy, 1);
    reset_n = 1;
    step();
    busy_len(n);
    chk("restart_busy_len", n, 8);
    fill(6, 1, 'h0FF);
    look("final_hit", 6, 'h0FF, 1, 1, 0);
    look("final_miss", 5, 'h1234, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
